chanarb: RTL and testbench

Collects finished event blocks from the per-channel processing stages and merges them into one 16-bit word stream for the readout FIFO. It sits directly downstream of the channel processors. It grants one channel at a time, round-robin, and drains that channel's complete block word-by-word using the channel's req/ack/dout handshake. A block is never interleaved with another block and is never split.

---
 rtl/chanarb_pkg.sv | 28 ++
 rtl/chanarb_rr.sv | 32 +++
 rtl/chanarb.sv | 124 ++++++++++++
 tb/tb_chanarb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chanarb_pkg.sv
// chanarb_pkg: state encodings, header field positions and block-size
// constants shared by the channel arbiter and its round-robin encoder.
package chanarb_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_HEAD = 4'b0010,
        S_COPY = 4'b0100,
        S_TAIL = 4'b1000
    } state_t;

    localparam int WW         = 16;
    localparam int HDR_SIG    = 15;
    localparam int HDR_TYPE   = 14;
    localparam int HDR_NUM_HI = 13;
    localparam int HDR_NUM_LO = 8;
    localparam int HDR_LEN_HI = 7;
    localparam int HDR_LEN_LO = 0;

    localparam int MAX_BLK = 257;
    localparam int REM_W   = $clog2(MAX_BLK);

    // Words remaining after the header: L for self trigger, L+1 for master.
    function automatic logic [REM_W-1:0] blk_rem(input logic [WW-1:0] hdr);
        return REM_W'(hdr[HDR_LEN_HI:HDR_LEN_LO]) + REM_W'(hdr[HDR_TYPE]);
    endfunction

endpackage

// File: rtl/chanarb_rr.sv
// chanarb_rr: round-robin priority encoder. The search starts one above the
// last granted channel and wraps, so the last winner has lowest priority.
module chanarb_rr #(
    parameter int NCH = 16,
    parameter int LW  = 4
) (
    input  logic [NCH-1:0] req,
    input  logic [LW-1:0]  last,
    output logic [LW-1:0]  gnt,
    output logic           any
);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        int s;
        logic [LW-1:0] idx;
        gnt = '0;
        any = 1'b0;
        s   = 0;
        idx = '0;
        for (int i = NCH; i >= 1; i--) begin
            s = int'(last) + i;
            if (s >= NCH) s = s - NCH;
            idx = s[LW-1:0];
            if (req[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chanarb.sv
// chanarb: merges complete event blocks from NCH channel stages into one
// 16-bit word stream, one whole block at a time, round-robin between channels.
// Optional macro CHANARB_ERRCHK_EN enables header/data format checks and the
// saturating errcnt; without it errcnt is tied to zero.
module chanarb
    import chanarb_pkg::*;
#(
    parameter int NCH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    ack,
    input  logic [16*NCH-1:0] din,
    input  logic              ofull,
    output logic [15:0]       odata,
    output logic              ovalid,
    output logic              busy,
    output logic [15:0]       errcnt
);

    localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state, nxt;
    logic [LW-1:0]    gch, last, rr_gnt;
    logic             rr_any;
    logic [REM_W-1:0] rem;
    logic [WW-1:0]    cur;
    logic             ack_on, hdr_bad, vld_d;

    chanarb_rr #(.NCH(NCH), .LW(LW)) u_rr (
        .req  (req),
        .last (last),
        .gnt  (rr_gnt),
        .any  (rr_any)
    );

    // Word currently presented by the granted channel.
    assign cur    = din[{gch, 4'b0000} +: WW];
    assign ack_on = (state == S_HEAD) || (state == S_COPY);
    assign busy   = (state != S_IDLE);

    // Ack is decoded from the state register so reset drops it at once.
    always_comb begin
        ack = '0;
        if (ack_on) ack[gch] = 1'b1;
    end

    // Next-state: a granted block always runs to its end once started.
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (rr_any && !ofull) nxt = S_HEAD;
            S_HEAD: begin
                if (hdr_bad)                 nxt = S_IDLE;
                else if (blk_rem(cur) == '0) nxt = S_TAIL;
                else                         nxt = S_COPY;
            end
            S_COPY: if (rem == REM_W'(1)) nxt = S_TAIL;
            S_TAIL: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // State register, grant latch, remaining-word counter, round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            gch   <= '0;
            last  <= LW'(NCH - 1);
            rem   <= '0;
        end else begin
            state <= nxt;
            unique case (state)
                S_IDLE: if (rr_any && !ofull) gch <= rr_gnt;
                S_HEAD: begin
                    rem <= blk_rem(cur);
                    if (hdr_bad) last <= gch;
                end
                S_COPY: rem <= rem - 1'b1;
                S_TAIL: last <= gch;
                default: ;
            endcase
        end
    end

    // Output datapath: an acked word shows up on din one cycle later and is
    // registered out the cycle after, so ovalid trails ack by two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odata  <= '0;
            vld_d  <= 1'b0;
            ovalid <= 1'b0;
        end else begin
            odata  <= cur;
            vld_d  <= ack_on && !((state == S_HEAD) && hdr_bad);
            ovalid <= vld_d;
        end
    end

`ifdef CHANARB_ERRCHK_EN
    logic hdr_d, dat_err;

    assign hdr_bad = ~cur[HDR_SIG];
    // Data words (not the header) must keep their top nibble clear.
    assign dat_err = vld_d & ~hdr_d & (|cur[15:12]);

    // Saturating format-error counter; the two error sources never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_d  <= 1'b0;
            errcnt <= '0;
        end else begin
            hdr_d <= (state == S_HEAD);
            if ((((state == S_HEAD) && hdr_bad) || dat_err) && (errcnt != 16'hFFFF))
                errcnt <= errcnt + 16'd1;
        end
    end
`else
    assign hdr_bad = 1'b0;
    assign errcnt  = '0;
`endif

endmodule

// File: tb/tb_chanarb.sv
// tb_chanarb: directed tests with a scoreboard; a channel-stage model serves
// words from per-channel memories using the registered req/ack/dout protocol.
module tb_chanarb;

    localparam int NCH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    req, ack;
    logic [16*NCH-1:0] din;
    logic              ofull = 1'b0;
    logic [15:0]       odata, errcnt;
    logic              ovalid, busy;

    chanarb #(.NCH(NCH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .ack    (ack),
        .din    (din),
        .ofull  (ofull),
        .odata  (odata),
        .ovalid (ovalid),
        .busy   (busy),
        .errcnt (errcnt)
    );

    always #4 clk = ~clk;

    // Channel stage model: dout registered from the read pointer.
    logic [15:0] mem [NCH][512];
    int          rp [NCH];
    int          wp [NCH];
    logic [15:0] dout [NCH];

    always @(posedge clk or posedge rst) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                rp[c]   <= 0;
                dout[c] <= 16'h0;
            end else begin
                dout[c] <= mem[c][rp[c]];
                if (ack[c]) rp[c] <= rp[c] + 1;
            end
        end
    end

    always_comb begin
        req = '0;
        din = '0;
        for (int c = 0; c < NCH; c++) begin
            din[16*c +: 16] = dout[c];
            req[c] = (rp[c] < wp[c]);
        end
    end

    // Scoreboard state
    logic [15:0]    expq [$];
    int             gq [$];
    int             checks = 0, errors = 0;
    int             cyc = 0;
    int             nack [NCH];
    logic [NCH-1:0] ack_prev = '0;
    int             t_ack0, t_ackl, t_vld0, n_vld;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: protocol check on ack, grant order capture, output compare.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(ack)) begin
                errors++;
                $display("FAIL ack_onehot got %h", ack);
            end
            if (|ack) begin
                if (t_ack0 < 0) t_ack0 = cyc;
                t_ackl = cyc;
                for (int c = 0; c < NCH; c++) if (ack[c]) nack[c]++;
                if (ack_prev == '0)
                    for (int c = 0; c < NCH; c++) if (ack[c]) gq.push_back(c);
            end
            ack_prev = ack;
            if (ovalid) begin
                logic [15:0] e;
                if (t_vld0 < 0) t_vld0 = cyc;
                n_vld++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL odata_unexpected got %h exp none", odata);
                end else begin
                    e = expq.pop_front();
                    if (odata !== e) begin
                        errors++;
                        $display("FAIL odata got %h exp %h", odata, e);
                    end
                end
            end
        end else begin
            ack_prev = '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    task automatic clr_rec();
        t_ack0 = -1; t_ackl = -1; t_vld0 = -1; n_vld = 0;
        for (int c = 0; c < NCH; c++) nack[c] = 0;
    endtask

    task automatic clr_all();
        expq.delete();
        gq.delete();
        for (int c = 0; c < NCH; c++) wp[c] = 0;
        clr_rec();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clr_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic put(input int c, input logic [15:0] w, input bit exp = 1'b1);
        mem[c][wp[c]] = w;
        wp[c]++;
        if (exp) expq.push_back(w);
    endtask

    task automatic drain(input int maxc);
        int i;
        for (i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !busy) break;
        end
        checks++;
        if (i == maxc) begin
            errors++;
            $display("FAIL drain_timeout got %0d words left exp 0", expq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic int gnt_at(input int k);
        return (gq.size() > k) ? gq[k] : -1;
    endfunction

    initial begin
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < 512; a++) mem[c][a] = 16'h0;
        clr_all();
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errcnt", errcnt, 0);
        chk("rst_odata", odata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Self block on channel 3, L=4
        clr_rec();
        put(3, 16'h8304); put(3, 16'h0011); put(3, 16'h0022);
        put(3, 16'h0033); put(3, 16'h0044);
        drain(100);
        chk("t1_acks", nack[3], 5);
        chk("t1_ack_span", t_ackl - t_ack0, 4);
        chk("t1_vld_lat", t_vld0 - t_ack0, 2);
        chk("t1_nvld", n_vld, 5);

        // Master block on channel 0, L=0
        clr_rec();
        put(0, 16'hC000); put(0, 16'h8123);
        drain(100);
        chk("t2_acks", nack[0], 2);
        chk("t2_nvld", n_vld, 2);

        // Round-robin among 1, 5, 15 with a second block waiting on 1
        do_reset();
        put(1, 16'h8102); put(1, 16'h0A01); put(1, 16'h0A02);
        put(5, 16'hC500); put(5, 16'h8555);
        put(15, 16'h8F02); put(15, 16'h0F01); put(15, 16'h0F02);
        put(1, 16'h8101); put(1, 16'h0B01);
        drain(200);
        chk("t3_ngrant", gq.size(), 4);
        chk("t3_grant0", gnt_at(0), 1);
        chk("t3_grant1", gnt_at(1), 5);
        chk("t3_grant2", gnt_at(2), 15);
        chk("t3_grant3", gnt_at(3), 1);
        chk("t3_acks1", nack[1], 5);

        // ofull blocks the grant; raising it mid-block does not stop the block
        do_reset();
        ofull = 1'b1;
        put(2, 16'hC2FF);
        for (int i = 0; i < 256; i++) put(2, 16'(i));
        repeat (20) @(negedge clk);
        chk("t4_hold_acks", nack[2], 0);
        chk("t4_hold_busy", busy, 0);
        ofull = 1'b0;
        repeat (60) @(negedge clk);
        ofull = 1'b1;
        drain(400);
        chk("t4_acks", nack[2], 257);
        chk("t4_nvld", n_vld, 257);
        ofull = 1'b0;

        // Reset in the middle of a block
        do_reset();
        put(7, 16'h870A);
        for (int i = 0; i < 10; i++) put(7, 16'h0700 + 16'(i));
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t5_pre_ack", ack, 32'h80);
        rst = 1'b1;
        #1;
        chk("t5_rst_ack", ack, 0);
        chk("t5_rst_busy", busy, 0);
        clr_all();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ovalid", ovalid, 0);
        put(0, 16'h8000);
        put(4, 16'h8400);
        drain(100);
        chk("t5_grant0", gnt_at(0), 0);
        chk("t5_grant1", gnt_at(1), 4);

`ifdef CHANARB_ERRCHK_EN
        // Bad header dropped and counted; bad data word forwarded and counted
        do_reset();
        put(3, 16'h0305, 1'b0);
        repeat (10) @(negedge clk);
        chk("t6_bad_acks", nack[3], 1);
        chk("t6_bad_nvld", n_vld, 0);
        chk("t6_errcnt1", errcnt, 1);
        put(3, 16'h8301); put(3, 16'h1ABC);
        drain(100);
        chk("t6_errcnt2", errcnt, 2);
`else
        chk("errcnt_off", errcnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
